// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: default 640x480@60 timing,
// the counter-width helper and the colour-bar palette used by the test pattern
// (enabled with VGA_TEST_PATTERN_EN).
package vga_pkg;

    // Default 640x480@60 raster (25.175 MHz pixel clock)
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // Colour bars: eight equal-width bars, index k drives {blue,green,red} = k
    localparam int unsigned NUM_BARS = 8;

    typedef enum logic [2:0] {
        BarBlack   = 3'd0,
        BarRed     = 3'd1,
        BarGreen   = 3'd2,
        BarYellow  = 3'd3,
        BarBlue    = 3'd4,
        BarMagenta = 3'd5,
        BarCyan    = 3'd6,
        BarWhite   = 3'd7
    } bar_colour_e;

    // Counter width large enough for the longer of the two raster dimensions
    function automatic int unsigned cnt_width(int unsigned h_total, int unsigned v_total);
        int unsigned longest;
        longest = (h_total > v_total) ? h_total : v_total;
        return $clog2(longest);
    endfunction

    // Bar index for a horizontal position; only meaningful while h < h_active
    function automatic logic [2:0] bar_index(int unsigned h, int unsigned h_active);
        int unsigned k;
        k = (h * NUM_BARS) / h_active;
        return k[2:0];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that advances only on enable; async active-low
// clear empties every stage.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift one stage per enabled tick, clear everything on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else if (en) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, sync/de generation, a
// PIPE_LAT-deep delay line matching the pixel source latency, and registered
// colour outputs blanked outside the visible area.
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_en input and
// an eight-bar colour test pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned CH_W     = 1,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_LAT = 1,
    localparam int unsigned CNT_W   = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP,
                                                V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_en,
`endif
    input  logic [3*CH_W-1:0] rgb_in,
    output logic [CH_W-1:0]   red_out,
    output logic [CH_W-1:0]   green_out,
    output logic [CH_W-1:0]   blue_out,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [CNT_W-1:0]  hor_count,
    output logic [CNT_W-1:0]  ver_count,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so sync end positions equal to 2**CNT_W still compare correctly
    localparam int unsigned CMP_W   = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CMP_W-1:0] H_VIS    = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_VIS    = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_START = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_END   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_START = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_END   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DLY_W = 7;
`else
    localparam int unsigned DLY_W = 4;
`endif

    logic [CMP_W-1:0]  hor_ext, ver_ext;
    logic              hs_raw, vs_raw, de_raw, fs_raw;
    logic [DLY_W-1:0]  dly_in, dly_out;
    logic [3*CH_W-1:0] pix_rgb;

    // Raster counters: hor wraps at line end and carries into ver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hor_count <= '0;
            ver_count <= '0;
        end else if (pix_en) begin
            if (hor_count == H_LAST) begin
                hor_count <= '0;
                ver_count <= (ver_count == V_LAST) ? '0 : ver_count + 1'b1;
            end else begin
                hor_count <= hor_count + 1'b1;
            end
        end
    end

    assign hor_ext = {1'b0, hor_count};
    assign ver_ext = {1'b0, ver_count};

    // Raw flags are polarity-free (1 = active) so cleared delay stages read as inactive
    assign hs_raw = (hor_ext >= HS_START) && (hor_ext < HS_END);
    assign vs_raw = (ver_ext >= VS_START) && (ver_ext < VS_END);
    assign de_raw = (hor_ext < H_VIS) && (ver_ext < V_VIS);
    assign fs_raw = (hor_count == '0) && (ver_count == '0);

`ifdef VGA_TEST_PATTERN_EN
    assign dly_in = {bar_index(32'(hor_count), H_ACTIVE), fs_raw, de_raw, vs_raw, hs_raw};
`else
    assign dly_in = {fs_raw, de_raw, vs_raw, hs_raw};
`endif

    vga_delay_line #(
        .WIDTH (DLY_W),
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .din   (dly_in),
        .dout  (dly_out)
    );

    // Pick the pixel source: external rgb_in, or the bar colour when the pattern is on
    always_comb begin
        pix_rgb = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (test_en) begin
            pix_rgb = {{CH_W{dly_out[6]}}, {CH_W{dly_out[5]}}, {CH_W{dly_out[4]}}};
        end
`endif
    end

    // Output register: colour and delayed timing for one coordinate update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
        end else if (pix_en) begin
            hsync       <= dly_out[0] ? SYNC_POL : ~SYNC_POL;
            vsync       <= dly_out[1] ? SYNC_POL : ~SYNC_POL;
            de          <= dly_out[2];
            frame_start <= dly_out[3];
            if (dly_out[2]) begin
                red_out   <= pix_rgb[CH_W-1:0];
                green_out <= pix_rgb[2*CH_W-1:CH_W];
                blue_out  <= pix_rgb[3*CH_W-1:2*CH_W];
            end else begin
                red_out   <= '0;
                green_out <= '0;
                blue_out  <= '0;
            end
        end
    end

endmodule
